zap_mem_arbiter: RTL and testbench

Single-port SRAM arbiter placed between the ZAP core and main memory. It replaces the dual-ported SRAM view with one shared port. Each cycle it grants either the instruction-fetch requester or the data (load/store) requester, routes read data back to the owner one cycle later, and stalls the loser. Data accesses have priority, and a bounded-starvation counter guarantees forward progress of fetch.

---
 rtl/zap_soc_pkg.sv | 19 +
 rtl/zap_mem_arb_sel.sv | 34 +++
 rtl/zap_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_zap_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/zap_soc_pkg.sv
// Shared definitions for the ZAP memory arbiter: read-owner encodings and
// starvation-counter sizing.
package zap_soc_pkg;

  localparam int DRUN_W       = 4;
  localparam int DEF_MAX_DRUN = 4;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IFETCH = 2'd1,
    OWN_DREAD  = 2'd2
  } own_e;

  // Byte-lane select used by the SRAM port: reads always fetch the full word.
  function automatic logic [3:0] mem_ben_of(input logic wr, input logic [3:0] ben);
    return wr ? ben : 4'hF;
  endfunction

endpackage

// File: rtl/zap_mem_arb_sel.sv
// Combinational grant selection between instruction fetch and data access,
// with the starvation limit that lets a pending fetch through.
module zap_mem_arb_sel
  import zap_soc_pkg::*;
#(
  parameter int MAX_DRUN = DEF_MAX_DRUN
) (
  input  logic              block,
  input  logic              ireq,
  input  logic              dreq,
  input  logic [DRUN_W-1:0] drun,
  output logic              pick_i,
  output logic              pick_d,
  output logic              gnt_i,
  output logic              gnt_d,
  output logic              istall,
  output logic              dstall
);

  logic at_limit;

  assign at_limit = (drun == DRUN_W'(MAX_DRUN));

  // Raw winner ignores reset so the SRAM address/data lines still track inputs.
  assign pick_d = dreq & ~(ireq & at_limit);
  assign pick_i = ireq & ~pick_d;

  assign gnt_d  = pick_d & ~block;
  assign gnt_i  = pick_i & ~block;

  assign istall = ireq & ~gnt_i;
  assign dstall = dreq & ~gnt_d;

endmodule

// File: rtl/zap_mem_arbiter.sv
// Single-port SRAM arbiter for the ZAP core: data accesses win, a bounded
// run counter guarantees fetch progress, read data returns one cycle later.
module zap_mem_arbiter
  import zap_soc_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_DRUN = DEF_MAX_DRUN
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ireq,
  input  logic [ADDR_W-1:0] i_iaddress,
  output logic              o_istall,
  output logic              o_ivalid,
  output logic [31:0]       o_idata,
  input  logic              i_drd,
  input  logic              i_dwr,
  input  logic [ADDR_W-1:0] i_daddress,
  input  logic [3:0]        i_dben,
  input  logic [31:0]       i_dwdata,
  output logic              o_dstall,
  output logic              o_dvalid,
  output logic [31:0]       o_drdata,
  output logic              o_mem_en,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_ben,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  logic              dreq;
  logic              pick_i;
  logic              pick_d;
  logic              gnt_i;
  logic              gnt_d;
  logic [DRUN_W-1:0] drun_reg;
  logic [DRUN_W-1:0] drun_next;
  own_e              rd_own_reg;
  own_e              rd_own_next;
  logic [31:0]       idata_hold_reg;
  logic [31:0]       drdata_hold_reg;

  assign dreq = i_drd | i_dwr;

  zap_mem_arb_sel #(
    .MAX_DRUN (MAX_DRUN)
  ) u_sel (
    .block  (i_reset),
    .ireq   (i_ireq),
    .dreq   (dreq),
    .drun   (drun_reg),
    .pick_i (pick_i),
    .pick_d (pick_d),
    .gnt_i  (gnt_i),
    .gnt_d  (gnt_d),
    .istall (o_istall),
    .dstall (o_dstall)
  );

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = '0;
    o_mem_ben   = 4'h0;
    o_mem_wdata = 32'h0;
    if (pick_d) begin
      o_mem_en    = ~i_reset;
      o_mem_wr    = i_dwr;
      o_mem_addr  = i_daddress;
      o_mem_ben   = mem_ben_of(i_dwr, i_dben);
      o_mem_wdata = i_dwdata;
    end else if (pick_i) begin
      o_mem_en    = ~i_reset;
      o_mem_addr  = i_iaddress;
      o_mem_ben   = 4'hF;
    end
  end

  always_comb begin
    rd_own_next = OWN_NONE;
    if (gnt_i) begin
      rd_own_next = OWN_IFETCH;
    end else if (gnt_d && i_drd) begin
      rd_own_next = OWN_DREAD;
    end

    // Count data grants only while a fetch is waiting; saturate at the limit.
    drun_next = drun_reg;
    if (gnt_i || !i_ireq) begin
      drun_next = '0;
    end else if (gnt_d && drun_reg != DRUN_W'(MAX_DRUN)) begin
      drun_next = drun_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_own_reg      <= OWN_NONE;
      drun_reg        <= '0;
      idata_hold_reg  <= 32'h0;
      drdata_hold_reg <= 32'h0;
    end else begin
      rd_own_reg <= rd_own_next;
      drun_reg   <= drun_next;
      if (rd_own_reg == OWN_IFETCH) begin
        idata_hold_reg <= i_mem_rdata;
      end
      if (rd_own_reg == OWN_DREAD) begin
        drdata_hold_reg <= i_mem_rdata;
      end
    end
  end

  // A read in flight when reset arrives is dropped: no pulse, data not routed.
  assign o_ivalid = (rd_own_reg == OWN_IFETCH) & ~i_reset;
  assign o_dvalid = (rd_own_reg == OWN_DREAD) & ~i_reset;
  assign o_idata  = o_ivalid ? i_mem_rdata : idata_hold_reg;
  assign o_drdata = o_dvalid ? i_mem_rdata : drdata_hold_reg;

endmodule

// File: tb/tb_zap_mem_arbiter.sv
// Directed, table-driven bench for zap_mem_arbiter with a behavioural SRAM.
module tb_zap_mem_arbiter;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_ireq;
  logic [31:0] i_iaddress;
  logic        o_istall;
  logic        o_ivalid;
  logic [31:0] o_idata;
  logic        i_drd;
  logic        i_dwr;
  logic [31:0] i_daddress;
  logic [3:0]  i_dben;
  logic [31:0] i_dwdata;
  logic        o_dstall;
  logic        o_dvalid;
  logic [31:0] o_drdata;
  logic        o_mem_en;
  logic        o_mem_wr;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_ben;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] A0 = 32'h1111_0000;
  localparam logic [31:0] A1 = 32'h2222_4444;
  localparam logic [31:0] A2 = 32'h3333_8888;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] BY = 32'h0000_AB00;

  always #5 clk = ~clk;

  zap_mem_arbiter #(.ADDR_W(32), .MAX_DRUN(4)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_ireq      (i_ireq),
    .i_iaddress  (i_iaddress),
    .o_istall    (o_istall),
    .o_ivalid    (o_ivalid),
    .o_idata     (o_idata),
    .i_drd       (i_drd),
    .i_dwr       (i_dwr),
    .i_daddress  (i_daddress),
    .i_dben      (i_dben),
    .i_dwdata    (i_dwdata),
    .o_dstall    (o_dstall),
    .o_dvalid    (o_dvalid),
    .o_drdata    (o_drdata),
    .o_mem_en    (o_mem_en),
    .o_mem_wr    (o_mem_wr),
    .o_mem_addr  (o_mem_addr),
    .o_mem_ben   (o_mem_ben),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata)
  );

  // Behavioural SRAM: byte-enabled writes, one-cycle registered reads.
  logic [31:0] mem [0:1023];
  initial i_mem_rdata = 32'h0;
  always @(posedge clk) begin
    if (o_mem_en && o_mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (o_mem_ben[b]) mem[o_mem_addr[11:2]][b*8 +: 8] <= o_mem_wdata[b*8 +: 8];
      end
    end else if (o_mem_en) begin
      i_mem_rdata <= mem[o_mem_addr[11:2]];
    end
  end

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        drd;
    logic        dwr;
    logic [31:0] daddr;
    logic [3:0]  dben;
    logic [31:0] dwdata;
    logic        e_istall;
    logic        e_dstall;
    logic        e_en;
    logic        e_wr;
    logic [3:0]  e_ben;
    logic [31:0] e_addr;
    logic        e_ivalid;
    logic        e_dvalid;
    logic [31:0] e_idata;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic drd,
                       input logic dwr, input logic [31:0] daddr, input logic [3:0] dben,
                       input logic [31:0] dwdata);
    i_ireq = ireq; i_iaddress = iaddr; i_drd = drd; i_dwr = dwr;
    i_daddress = daddr; i_dben = dben; i_dwdata = dwdata;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = A0; mem[1] = A1; mem[2] = A2;

    // Field order: ireq iaddr drd dwr daddr dben dwdata | istall dstall en wr ben addr ivalid dvalid idata drdata
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,         0, 0, 1, 0, 4'hF, 0,     0, 0, 0,  0};
    vecs[1]  = '{1, 4, 0, 0, 0, 0, 0,         0, 0, 1, 0, 4'hF, 4,     1, 0, A0, 0};
    vecs[2]  = '{1, 8, 0, 0, 0, 0, 0,         0, 0, 1, 0, 4'hF, 8,     1, 0, A1, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 4'h0, 0,     1, 0, A2, 0};
    vecs[4]  = '{0, 0, 0, 1, 6000, 4'hF, DB,  0, 0, 1, 1, 4'hF, 6000,  0, 0, A2, 0};
    vecs[5]  = '{0, 0, 1, 0, 6000, 0, 0,      0, 0, 1, 0, 4'hF, 6000,  0, 0, A2, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 4'h0, 0,     0, 1, A2, DB};
    vecs[7]  = '{0, 0, 0, 1, 'h100, 4'b0010, BY, 0, 0, 1, 1, 4'b0010, 'h100, 0, 0, A2, DB};
    vecs[8]  = '{0, 0, 1, 0, 'h100, 0, 0,     0, 0, 1, 0, 4'hF, 'h100, 0, 0, A2, DB};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 4'h0, 0,     0, 1, A2, BY};
    vecs[10] = '{1, 4, 1, 0, 6000, 0, 0,      1, 0, 1, 0, 4'hF, 6000,  0, 0, A2, BY};
    vecs[11] = '{1, 4, 0, 0, 0, 0, 0,         0, 0, 1, 0, 4'hF, 4,     0, 1, A2, DB};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 4'h0, 0,     1, 0, A1, DB};
    vecs[13] = '{1, 8, 1, 0, 6000, 0, 0,      1, 0, 1, 0, 4'hF, 6000,  0, 0, A1, DB};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 4'h0, 0,     0, 1, A1, DB};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 4'h0, 0,     0, 0, A1, DB};

    // Reset with both requests pending: stalls high, no SRAM access, clean outputs.
    i_reset = 1'b1;
    drive(1, 32'h40, 1, 0, 32'h80, 4'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_istall", 32'(o_istall), 32'd1);
    chk("rst_dstall", 32'(o_dstall), 32'd1);
    chk("rst_mem_en", 32'(o_mem_en), 32'd0);
    chk("rst_ivalid", 32'(o_ivalid), 32'd0);
    chk("rst_dvalid", 32'(o_dvalid), 32'd0);
    chk("rst_idata", o_idata, 32'h0);
    chk("rst_drdata", o_drdata, 32'h0);
    $display("reset: istall=%0b dstall=%0b mem_en=%0b", o_istall, o_dstall, o_mem_en);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    i_reset = 1'b0;

    for (int v = 0; v < 16; v++) begin
      drive(vecs[v].ireq, vecs[v].iaddr, vecs[v].drd, vecs[v].dwr,
            vecs[v].daddr, vecs[v].dben, vecs[v].dwdata);
      @(negedge clk);
      chk($sformatf("v%0d_istall", v), 32'(o_istall), 32'(vecs[v].e_istall));
      chk($sformatf("v%0d_dstall", v), 32'(o_dstall), 32'(vecs[v].e_dstall));
      chk($sformatf("v%0d_mem_en", v), 32'(o_mem_en), 32'(vecs[v].e_en));
      chk($sformatf("v%0d_mem_wr", v), 32'(o_mem_wr), 32'(vecs[v].e_wr));
      chk($sformatf("v%0d_mem_ben", v), 32'(o_mem_ben), 32'(vecs[v].e_ben));
      chk($sformatf("v%0d_mem_addr", v), o_mem_addr, vecs[v].e_addr);
      chk($sformatf("v%0d_ivalid", v), 32'(o_ivalid), 32'(vecs[v].e_ivalid));
      chk($sformatf("v%0d_dvalid", v), 32'(o_dvalid), 32'(vecs[v].e_dvalid));
      chk($sformatf("v%0d_idata", v), o_idata, vecs[v].e_idata);
      chk($sformatf("v%0d_drdata", v), o_drdata, vecs[v].e_drdata);
      $display("vec %0d: istall=%0b dstall=%0b en=%0b wr=%0b addr=%h ivalid=%0b dvalid=%0b idata=%h drdata=%h",
               v, o_istall, o_dstall, o_mem_en, o_mem_wr, o_mem_addr, o_ivalid, o_dvalid, o_idata, o_drdata);
      @(posedge clk); #1;
    end

    // Continuous contention: four data grants, then the starved fetch, repeating.
    for (int k = 0; k < 10; k++) begin
      logic exp_i;
      logic prev_i;
      exp_i  = ((k % 5) == 4);
      prev_i = (k > 0) && (((k - 1) % 5) == 4);
      drive(1, 32'h10, 1, 0, 32'h20, 4'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("cont%0d_istall", k), 32'(o_istall), 32'(!exp_i));
      chk($sformatf("cont%0d_dstall", k), 32'(o_dstall), 32'(exp_i));
      chk($sformatf("cont%0d_addr", k), o_mem_addr, exp_i ? 32'h10 : 32'h20);
      if (k > 0) begin
        chk($sformatf("cont%0d_ivalid", k), 32'(o_ivalid), 32'(prev_i));
        chk($sformatf("cont%0d_dvalid", k), 32'(o_dvalid), 32'(!prev_i));
      end
      $display("cont %0d: grant=%s istall=%0b dstall=%0b", k, o_istall ? "D" : "I", o_istall, o_dstall);
      @(posedge clk); #1;
    end

    // Reset arrives the cycle after a read grant: the return is discarded.
    drive(0, 0, 1, 0, 32'd6000, 4'h0, 32'h0);
    @(posedge clk); #1;
    i_reset = 1'b1;
    drive(1, 32'h4, 1, 0, 32'd6000, 4'h0, 32'h0);
    @(negedge clk);
    chk("rmid_dvalid", 32'(o_dvalid), 32'd0);
    chk("rmid_ivalid", 32'(o_ivalid), 32'd0);
    chk("rmid_mem_en", 32'(o_mem_en), 32'd0);
    chk("rmid_dstall", 32'(o_dstall), 32'd1);
    $display("reset mid-read: dvalid=%0b ivalid=%0b mem_en=%0b", o_dvalid, o_ivalid, o_mem_en);
    @(posedge clk); #1;
    i_reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rpost_dvalid", 32'(o_dvalid), 32'd0);
    chk("rpost_ivalid", 32'(o_ivalid), 32'd0);
    chk("rpost_drdata", o_drdata, 32'h0);
    chk("rpost_idata", o_idata, 32'h0);
    $display("after reset: dvalid=%0b ivalid=%0b drdata=%h idata=%h", o_dvalid, o_ivalid, o_drdata, o_idata);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
